// File: rtl/vending_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : vending_pkg
//  Description : Shared note codes, denomination values and dispenser states
//                used by the vending machine note/coin return path.
//  Revision    : 1.0 - initial release
// ============================================================================
package vending_pkg;

    // 3-bit note code space shared with the note acceptor
    typedef enum logic [2:0] {
        NOTE_10   = 3'b000,
        NOTE_20   = 3'b001,
        NOTE_50   = 3'b010,
        NOTE_100  = 3'b011,
        NOTE_200  = 3'b100,
        NOTE_500  = 3'b101,
        NOTE_5    = 3'b110,
        NOTE_NONE = 3'b111
    } note_code_t;

    // Dispenser controller states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_PRESENT = 3'd2,
        ST_DONE    = 3'd3,
        ST_FAULT   = 3'd4
    } disp_state_t;

    // Number of real denominations (NOTE_NONE excluded)
    localparam int c_num_denom = 7;

    // Denominations ordered largest first; the picker walks this list
    localparam note_code_t c_priority [c_num_denom] = '{
        NOTE_500, NOTE_200, NOTE_100, NOTE_50, NOTE_20, NOTE_10, NOTE_5
    };

    // Rupee value of a note code; NOTE_NONE is worth nothing
    function automatic logic [15:0] denom_value(input note_code_t code);
        case (code)
            NOTE_10:  return 16'd10;
            NOTE_20:  return 16'd20;
            NOTE_50:  return 16'd50;
            NOTE_100: return 16'd100;
            NOTE_200: return 16'd200;
            NOTE_500: return 16'd500;
            NOTE_5:   return 16'd5;
            default:  return 16'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/denom_select.sv
`default_nettype none
// ============================================================================
//  Module      : denom_select
//  Description : Combinational greedy picker. Returns the largest denomination
//                whose value fits in the remaining amount and whose stock is
//                available. found=0 when nothing fits.
//  Revision    : 1.0 - initial release
// ============================================================================
module denom_select
    import vending_pkg::*;
#(
    parameter int AMT_W = 10
) (
    input  logic [AMT_W-1:0]       remaining,
    input  logic [c_num_denom-1:0] avail,
    output note_code_t             code,
    output logic                   found
);

    // Walk smallest to largest so the largest eligible denomination wins last
    always_comb begin
        code  = NOTE_NONE;
        found = 1'b0;
        for (int i = c_num_denom - 1; i >= 0; i--) begin
            if (avail[c_priority[i]] &&
                (32'(denom_value(c_priority[i])) <= 32'(remaining))) begin
                code  = c_priority[i];
                found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
//  Module      : change_dispenser
//  Description : Vending machine return path. Accepts a change amount and
//                ejects it as a sequence of note codes (greedy, largest
//                first), one per note_valid/note_ack handshake. Reports a
//                one-cycle done pulse or a sticky fault with the residual.
//  Options     : CHANGE_DISPENSER_STOCK_EN - per-denomination stock counters
//                with refill; when undefined stock is unlimited.
//  Revision    : 1.0 - initial release
// ============================================================================
module change_dispenser
    import vending_pkg::*;
#(
    parameter int AMT_W      = 10,
    parameter int INIT_STOCK = 8,
    parameter int STOCK_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             change_valid,
    input  logic [AMT_W-1:0] change_amt,
    output logic             change_ready,
    output logic [2:0]       note_out,
    output logic             note_valid,
    input  logic             note_ack,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] residual,
    input  logic             fault_clr,
    input  logic             refill
);

    disp_state_t r_state;
    disp_state_t w_next;

    logic [AMT_W-1:0] r_remaining;
    logic [AMT_W-1:0] w_remaining;
    note_code_t       r_note_out;
    note_code_t       w_note_out;
    logic             r_note_valid;
    logic             w_note_valid;
    logic             r_done;
    logic             w_done;
    logic             r_fault;
    logic             w_fault;
    logic             w_dec;

    logic [c_num_denom-1:0] w_avail;
    note_code_t             w_sel_code;
    logic                   w_sel_found;
    logic [AMT_W-1:0]       w_val;

    // Value of the note currently being presented
    assign w_val = AMT_W'(denom_value(r_note_out));

    denom_select #(
        .AMT_W (AMT_W)
    ) u_denom_select (
        .remaining (r_remaining),
        .avail     (w_avail),
        .code      (w_sel_code),
        .found     (w_sel_found)
    );

`ifdef CHANGE_DISPENSER_STOCK_EN
    localparam logic [STOCK_W-1:0] c_init_stock = STOCK_W'(INIT_STOCK);

    generate
        for (genvar g = 0; g < c_num_denom; g++) begin : g_stock
            localparam logic [2:0] c_code = 3'(g);
            logic [STOCK_W-1:0] r_stock;

            // Reload on reset or an IDLE refill; decrement when this note is taken
            always_ff @(posedge clk) begin
                if (reset || ((r_state == ST_IDLE) && refill)) begin
                    r_stock <= c_init_stock;
                end else if (w_dec && (r_note_out == note_code_t'(c_code))) begin
                    r_stock <= r_stock - 1'b1;
                end
            end

            assign w_avail[g] = (r_stock != '0);
        end
    endgenerate
`else
    logic w_unused_stock;

    // Unlimited stock: every denomination is always available
    assign w_avail        = '1;
    assign w_unused_stock = ^{refill, INIT_STOCK[0], STOCK_W[0]};
`endif

    // Next-state and next-output logic for the dispense sequence
    always_comb begin
        w_next       = r_state;
        w_remaining  = r_remaining;
        w_note_out   = r_note_out;
        w_note_valid = r_note_valid;
        w_done       = 1'b0;
        w_fault      = r_fault;
        w_dec        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (change_valid) begin
                    w_remaining = change_amt;
                    if ((change_amt % AMT_W'(5)) != '0) begin
                        w_next  = ST_FAULT;
                        w_fault = 1'b1;
                    end else if (change_amt == '0) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next = ST_SELECT;
                    end
                end
            end

            ST_SELECT: begin
                if (w_sel_found) begin
                    w_note_out   = w_sel_code;
                    w_note_valid = 1'b1;
                    w_next       = ST_PRESENT;
                end else begin
                    w_fault = 1'b1;
                    w_next  = ST_FAULT;
                end
            end

            ST_PRESENT: begin
                if (note_ack) begin
                    w_remaining  = r_remaining - w_val;
                    w_note_out   = NOTE_NONE;
                    w_note_valid = 1'b0;
                    w_dec        = 1'b1;
                    w_next       = (w_remaining == '0) ? ST_DONE : ST_SELECT;
                end
            end

            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end

            ST_FAULT: begin
                if (fault_clr) begin
                    w_fault = 1'b0;
                    w_next  = ST_IDLE;
                end
            end

            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_remaining  <= '0;
            r_note_out   <= NOTE_NONE;
            r_note_valid <= 1'b0;
            r_done       <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_remaining  <= w_remaining;
            r_note_out   <= w_note_out;
            r_note_valid <= w_note_valid;
            r_done       <= w_done;
            r_fault      <= w_fault;
        end
    end

    assign change_ready = (r_state == ST_IDLE) && !reset;
    assign note_out     = r_note_out;
    assign note_valid   = r_note_valid;
    assign done         = r_done;
    assign fault        = r_fault;
    assign residual     = r_remaining;

endmodule
`default_nettype wire
